// File: rtl/cache_linefill.sv
// Critical-word-first line fill engine for a 32-word cache line.
// Fetches one word per memory transaction starting at the missed word,
// wraps modulo 32, streams each word into the line RAM and flags the
// critical word on arrival. Each word occupies a request cycle and then a
// write cycle, during which no new request is issued.
module cache_linefill (
    input  logic        clk,
    input  logic        reset,
    input  logic        fill_req,
    input  logic [31:0] fill_addr,
    input  logic        invalidate,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        crit_valid,
    output logic [31:0] crit_data,
    output logic        line_valid,
    output logic [24:0] line_tag,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [4:0]  ram_waddr,
    output logic [31:0] ram_datain,
    output logic        ram_we
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [24:0] tag_q, tag_d;
    logic [4:0]  start_q, start_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        inval_q, inval_d;
    logic        line_valid_q, line_valid_d;
    logic        crit_valid_q, crit_valid_d;
    logic [31:0] crit_data_q, crit_data_d;
    logic        ram_we_q, ram_we_d;
    logic [4:0]  ram_waddr_q, ram_waddr_d;
    logic [31:0] ram_datain_q, ram_datain_d;

    logic [4:0]  widx;
    logic        accept;

    // Current word index wraps naturally in 5 bits.
    assign widx   = start_q + cnt_q;
    // The cycle carrying a RAM write is the write half of a word: no request.
    assign mem_req  = (state_q == StReq) && !ram_we_q;
    assign mem_addr = {tag_q, widx, 2'b00};
    assign accept   = (mem_req && mem_ack && mem_rvalid) ||
                      ((state_q == StWait) && mem_rvalid);

    assign fill_busy  = (state_q != StIdle);
    assign fill_done  = (state_q == StDone);
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign line_valid = line_valid_q;
    assign line_tag   = tag_q;
    assign ram_we     = ram_we_q;
    assign ram_waddr  = ram_waddr_q;
    assign ram_datain = ram_datain_q;

    // Next-state, word counter, invalidate latch and RAM write staging.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        start_d      = start_q;
        cnt_d        = cnt_q;
        inval_d      = inval_q;
        line_valid_d = line_valid_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        ram_we_d     = 1'b0;
        ram_waddr_d  = ram_waddr_q;
        ram_datain_d = ram_datain_q;

        unique case (state_q)
            StIdle: begin
                if (fill_req) begin
                    // A simultaneous invalidate is moot: the new fill clears the line.
                    state_d      = StReq;
                    tag_d        = fill_addr[31:7];
                    start_d      = fill_addr[6:2];
                    cnt_d        = 5'd0;
                    line_valid_d = 1'b0;
                    inval_d      = 1'b0;
                end else if (invalidate) begin
                    line_valid_d = 1'b0;
                end
            end
            StReq: begin
                if (mem_req && mem_ack && !mem_rvalid) begin
                    state_d = StWait;
                end
                if (invalidate) begin
                    inval_d = 1'b1;
                end
            end
            StWait: begin
                if (invalidate) begin
                    inval_d = 1'b1;
                end
            end
            StDone: begin
                state_d      = StIdle;
                line_valid_d = !(inval_q || invalidate);
                inval_d      = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            ram_we_d     = 1'b1;
            ram_waddr_d  = widx;
            ram_datain_d = mem_rdata;
            cnt_d        = cnt_q + 5'd1;
            state_d      = (cnt_q == 5'd31) ? StDone : StReq;
            if (cnt_q == 5'd0) begin
                crit_valid_d = 1'b1;
                crit_data_d  = mem_rdata;
            end
        end
    end

    // State registers with synchronous reset overriding every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            start_q      <= '0;
            cnt_q        <= '0;
            inval_q      <= 1'b0;
            line_valid_q <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            ram_we_q     <= 1'b0;
            ram_waddr_q  <= '0;
            ram_datain_q <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            inval_q      <= inval_d;
            line_valid_q <= line_valid_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            ram_we_q     <= ram_we_d;
            ram_waddr_q  <= ram_waddr_d;
            ram_datain_q <= ram_datain_d;
        end
    end

endmodule

// File: tb/tb_cache_linefill.sv
// Bench for cache_linefill: table of fills driven against a small memory
// model, RAM writes checked against a queue of expected writes, plus
// hand-written sequences for idle invalidate and mid-fill reset.
module tb_cache_linefill;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill_req;
    logic [31:0] fill_addr;
    logic        invalidate;
    logic        fill_busy;
    logic        fill_done;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        line_valid;
    logic [24:0] line_tag;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [4:0]  ram_waddr;
    logic [31:0] ram_datain;
    logic        ram_we;

    cache_linefill dut (
        .clk        (clk),
        .reset      (reset),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .invalidate (invalidate),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .line_valid (line_valid),
        .line_tag   (line_tag),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .ram_waddr  (ram_waddr),
        .ram_datain (ram_datain),
        .ram_we     (ram_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    // mode 0: ack+rvalid same cycle; 1: ack at once, rvalid 2 later;
    // 2: ack one cycle late, rvalid the cycle after ack.
    typedef struct {
        logic [31:0] addr;
        int          mode;
        logic        inval_start;
        logic        inval_mid;
        logic        extra_req;
        logic [31:0] first_ma;
        logic [31:0] last_ma;
        logic        exp_valid;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt, crit_cnt, done_cnt, done_cyc;
    int          mode = 1;
    int          pend = 0;
    logic        stall = 1'b0;
    logic        noise_en = 1'b1;
    logic        got_first;
    logic [31:0] pend_addr = '0;
    logic [31:0] first_seen, last_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: observe outputs after the edge, then drive memory for the next edge.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                chk("stray_we", 64'(ram_we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(ram_waddr), 64'(e.a));
                chk("wr_data", 64'(ram_datain), 64'(e.d));
            end
            wr_cnt++;
        end
        if (crit_valid) begin
            crit_cnt++;
            chk("crit_with_we", 64'(ram_we), 64'd1);
        end
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0BAD_F00D;
        if (reset) begin
            pend  = 0;
            stall = 1'b0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_addr;
            end
        end else if (mem_req) begin
            if (mode == 2 && !stall) begin
                stall = 1'b1;
            end else begin
                stall   = 1'b0;
                mem_ack = 1'b1;
                if (!got_first) first_seen = mem_addr;
                got_first = 1'b1;
                last_seen = mem_addr;
                pend_addr = mem_addr;
                if (mode == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_addr;
                end else begin
                    pend = (mode == 1) ? 2 : 1;
                end
            end
        end else if (noise_en && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_flags"}, 64'({fill_busy, fill_done, crit_valid, line_valid, mem_req, ram_we}),
            64'd0);
        chk({nm, "_tag"}, 64'(line_tag), 64'd0);
        chk({nm, "_crit"}, 64'(crit_data), 64'd0);
        chk({nm, "_maddr"}, 64'(mem_addr), 64'd0);
        chk({nm, "_waddr"}, 64'(ram_waddr), 64'd0);
        chk({nm, "_wdata"}, 64'(ram_datain), 64'd0);
    endtask

    task automatic push_line(input logic [31:0] addr);
        logic [4:0]  idx;
        logic [4:0]  s;
        logic [24:0] tag;
        s   = addr[6:2];
        tag = addr[31:7];
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            idx = s + 5'(i);
            exp_q.push_back('{a: idx, d: {tag, idx, 2'b00}});
        end
        wr_cnt    = 0;
        crit_cnt  = 0;
        done_cnt  = 0;
        got_first = 1'b0;
    endtask

    task automatic run_fill(input vec_t v);
        int   start_cyc;
        int   guard;
        logic inv_fired;
        push_line(v.addr);
        mode       = v.mode;
        fill_addr  = v.addr;
        fill_req   = 1'b1;
        invalidate = v.inval_start;
        start_cyc  = cyc;
        tick();
        fill_req   = 1'b0;
        invalidate = 1'b0;
        fill_addr  = 32'h5555_5504;
        chk("start_busy", 64'(fill_busy), 64'd1);
        chk("start_lv", 64'(line_valid), 64'd0);
        chk("start_tag", 64'(line_tag), 64'(v.addr[31:7]));
        guard     = 0;
        inv_fired = 1'b0;
        while (done_cnt == 0 && guard < 600) begin
            invalidate = 1'b0;
            if (v.inval_mid && wr_cnt == 10 && !inv_fired) begin
                invalidate = 1'b1;
                inv_fired  = 1'b1;
            end
            fill_req = v.extra_req && wr_cnt >= 5 && wr_cnt < 8;
            tick();
            guard++;
        end
        invalidate = 1'b0;
        fill_req   = 1'b0;
        if (done_cnt == 0) begin
            chk("fill_timeout", 64'(fill_done), 64'd1);
        end else if (v.mode == 0) begin
            // Cycles spanned from the fill_req cycle through the fill_done cycle.
            chk("done_latency", 64'(done_cyc - start_cyc + 1), 64'd65);
        end
        tick();
        chk("end_busy", 64'(fill_busy), 64'd0);
        chk("end_lv", 64'(line_valid), 64'(v.exp_valid));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("crit_count", 64'(crit_cnt), 64'd1);
        chk("write_count", 64'(wr_cnt), 64'd32);
        chk("crit_data", 64'(crit_data), 64'(v.first_ma));
        chk("first_maddr", 64'(first_seen), 64'(v.first_ma));
        chk("last_maddr", 64'(last_seen), 64'(v.last_ma));
        for (int i = 0; i < 3; i++) tick();
        chk("hold_tag", 64'(line_tag), 64'(v.addr[31:7]));
        chk("hold_lv", 64'(line_valid), 64'(v.exp_valid));
    endtask

    initial begin
        int guard;
        vecs[0] = '{addr: 32'h0000_1000, mode: 1, inval_start: 0, inval_mid: 0, extra_req: 0,
                    first_ma: 32'h0000_1000, last_ma: 32'h0000_107C, exp_valid: 1};
        vecs[1] = '{addr: 32'h0000_20F4, mode: 1, inval_start: 0, inval_mid: 0, extra_req: 0,
                    first_ma: 32'h0000_20F4, last_ma: 32'h0000_20F0, exp_valid: 1};
        vecs[2] = '{addr: 32'h0000_20F4, mode: 0, inval_start: 0, inval_mid: 0, extra_req: 0,
                    first_ma: 32'h0000_20F4, last_ma: 32'h0000_20F0, exp_valid: 1};
        vecs[3] = '{addr: 32'hABCD_E07B, mode: 2, inval_start: 0, inval_mid: 1, extra_req: 1,
                    first_ma: 32'hABCD_E078, last_ma: 32'hABCD_E074, exp_valid: 0};
        vecs[4] = '{addr: 32'hFFFF_FF80, mode: 0, inval_start: 1, inval_mid: 0, extra_req: 0,
                    first_ma: 32'hFFFF_FF80, last_ma: 32'hFFFF_FFFC, exp_valid: 1};

        reset      = 1'b1;
        fill_req   = 1'b0;
        fill_addr  = '0;
        invalidate = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        wr_cnt     = 0;
        crit_cnt   = 0;
        done_cnt   = 0;
        done_cyc   = 0;
        got_first  = 1'b0;
        first_seen = '0;
        last_seen  = '0;
        tick();
        tick();
        reset = 1'b0;
        check_zero("reset");

        for (int i = 0; i < 5; i++) run_fill(vecs[i]);

        // Invalidate while idle drops the line but keeps the tag.
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        chk("idle_inval_lv", 64'(line_valid), 64'd0);
        chk("idle_inval_tag", 64'(line_tag), 64'h1FF_FFFF);

        // Reset after word 5 of a fill, with competing inputs on the reset edge.
        push_line(32'h0000_3000);
        mode      = 1;
        fill_addr = 32'h0000_3000;
        fill_req  = 1'b1;
        tick();
        fill_req = 1'b0;
        guard    = 0;
        while (wr_cnt < 6 && guard < 200) begin
            tick();
            guard++;
        end
        chk("pre_reset_writes", 64'(wr_cnt), 64'd6);
        exp_q.delete();
        reset      = 1'b1;
        fill_req   = 1'b1;
        invalidate = 1'b1;
        tick();
        reset      = 1'b0;
        fill_req   = 1'b0;
        invalidate = 1'b0;
        check_zero("abort");
        mem_ack    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid_we", 64'(ram_we), 64'd0);
            chk("late_rvalid_busy", 64'(fill_busy), 64'd0);
            tick();
        end
        run_fill('{addr: 32'h0000_3000, mode: 1, inval_start: 0, inval_mid: 0, extra_req: 0,
                   first_ma: 32'h0000_3000, last_ma: 32'h0000_307C, exp_valid: 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
